// File: rtl/spm_ctrl_pkg.sv
// Shared types and sizing for the serial-parallel multiplier controller.
package spm_ctrl_pkg;

  localparam int SPM_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Counter must reach 2*size inclusive.
  function automatic int cnt_width(input int size);
    return $clog2(2 * size + 1);
  endfunction

endpackage

// File: rtl/spm.sv
// Serial-parallel signed multiplier: x in parallel, y serial LSB first,
// product bits out LSB first, registered one cycle behind y.
module spm #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] x,
  input  logic            y,
  output logic            p
);

  logic [SIZE:0] r_acc;
  logic [SIZE:0] w_addend;
  logic [SIZE:0] w_sum;

  // One guard bit keeps the partial sum exact for any signed x.
  assign w_addend = y ? {x[SIZE-1], x} : '0;
  assign w_sum    = r_acc + w_addend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      p     <= 1'b0;
    end else begin
      r_acc <= {w_sum[SIZE], w_sum[SIZE:1]};
      p     <= w_sum[0];
    end
  end

endmodule

// File: rtl/spm_ctrl.sv
// Request/response controller around the serial multiplier spm.
// valid/ready: a transfer happens on a rising edge where valid and ready are both high.
module spm_ctrl
  import spm_ctrl_pkg::*;
#(
  parameter int SIZE = SPM_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [SIZE-1:0]   req_x,
  input  logic [SIZE-1:0]   req_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2*SIZE-1:0] rsp_p,
  output logic              busy,
  output state_t            dbg_state
);

  localparam int            CW   = cnt_width(SIZE);
  localparam logic [CW-1:0] LAST = CW'(2 * SIZE);

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [SIZE-1:0]   r_x;
  logic [SIZE-1:0]   r_y;
  logic [2*SIZE-1:0] r_p;
  logic              r_clear;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              r_busy;
  logic              w_spm_rst;
  logic              w_y_bit;
  logic              w_p_bit;

  // Clear comes straight from a flop so the multiplier reset is glitch-free.
  assign w_spm_rst = rst | r_clear;
  assign w_y_bit   = r_y[0];

  spm #(.SIZE(SIZE)) u_spm (
    .clk (clk),
    .rst (w_spm_rst),
    .x   (r_x),
    .y   (w_y_bit),
    .p   (w_p_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_p         <= '0;
      r_clear     <= 1'b1;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid && r_req_ready) begin
            r_x         <= req_x;
            r_y         <= req_y;
            r_state     <= CLEAR;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        CLEAR: begin
          r_state <= RUN;
          r_cnt   <= '0;
          r_clear <= 1'b0;
        end
        RUN: begin
          if (r_cnt != LAST) begin
            r_y <= {r_y[SIZE-1], r_y[SIZE-1:1]};
          end
          // spm output lags its input by one cycle, so capture starts at cnt 1.
          if (r_cnt != '0) begin
            r_p <= {w_p_bit, r_p[2*SIZE-1:1]};
          end
          if (r_cnt == LAST) begin
            r_state     <= DONE;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
            r_clear     <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_p     = r_p;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_spm_ctrl.sv
// Directed and random checks of spm_ctrl with SIZE = 32.
module tb_spm_ctrl;
  import spm_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_p;
  logic        busy;
  state_t      dbg_state;

  int          n_cmp;
  int          n_err;
  int          cyc;
  int          acc_cyc[$];
  logic [63:0] exp_q[$];

  spm_ctrl #(.SIZE(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // acceptance-edge recorder for throughput measurement
  initial cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_valid && req_ready) acc_cyc.push_back(cyc);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
    longint sx;
    longint sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return 64'(sx * sy);
  endfunction

  // driver tasks
  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_x     = x;
    req_y     = y;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic mul_directed(input string tag, input logic [31:0] x, input logic [31:0] y,
                              input logic [63:0] exp);
    int lat;
    rsp_ready = 1'b1;
    issue(x, y);
    wait_rsp(lat);
    check({tag, "_latency"}, 64'(lat), 64'd66);
    check({tag, "_p"}, rsp_p, exp);
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    int          lat;
    int          seen;
    int          n;
    int          stall;
    logic [31:0] rx;
    logic [31:0] ry;
    logic [63:0] held;

    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b0;

    // reset values while rst is high
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_p", rsp_p, 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_req_ready", 64'(req_ready), 64'd1);

    // 3*5 with busy/ready during CLEAR
    rsp_ready = 1'b1;
    issue(32'd3, 32'd5);
    check("clear_state", 64'(dbg_state), 64'(CLEAR));
    check("clear_busy", 64'(busy), 64'd1);
    check("clear_req_ready", 64'(req_ready), 64'd0);
    wait_rsp(lat);
    check("mul3x5_latency", 64'(lat), 64'd66);
    check("mul3x5_p", rsp_p, 64'h000000000000000F);
    @(posedge clk);
    #1;
    check("mul3x5_idle_busy", 64'(busy), 64'd0);
    check("mul3x5_idle_ready", 64'(req_ready), 64'd1);

    mul_directed("neg1x1", 32'hFFFFFFFF, 32'd1, 64'hFFFFFFFFFFFFFFFF);
    mul_directed("1xneg1", 32'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    mul_directed("maxpos", 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001);
    mul_directed("maxneg", 32'h80000000, 32'h80000000, 64'h4000000000000000);

    // back-to-back with a 10-cycle response stall; new operands offered while busy
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_x     = 32'hFFFFFFFE;
    req_y     = 32'h00000010;
    @(posedge clk);
    #1;
    req_x = 32'd5;
    req_y = 32'd9;
    wait_rsp(lat);
    check("b2b_first_latency", 64'(lat), 64'd66);
    check("b2b_first_p", rsp_p, 64'hFFFFFFFFFFFFFFE0);
    held = rsp_p;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (rsp_p !== held || req_ready !== 1'b0 || rsp_valid !== 1'b1) seen++;
    end
    check("b2b_stall_hold", 64'(seen), 64'd0);
    check("b2b_stall_p", rsp_p, 64'hFFFFFFFFFFFFFFE0);
    check("b2b_stall_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("b2b_idle_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("b2b_second_accepted", 64'(dbg_state), 64'(CLEAR));
    wait_rsp(lat);
    check("b2b_second_latency", 64'(lat), 64'd66);
    check("b2b_second_p", rsp_p, 64'h000000000000002D);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;

    // throughput with req_valid and rsp_ready held high
    acc_cyc.delete();
    @(negedge clk);
    req_valid = 1'b1;
    req_x     = 32'd2;
    req_y     = 32'd3;
    n = 0;
    while (acc_cyc.size() < 2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    check("tput_accepts", 64'(acc_cyc.size()), 64'd2);
    if (acc_cyc.size() >= 2) check("tput_period", 64'(acc_cyc[1] - acc_cyc[0]), 64'd68);
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("tput_drain", 64'(busy), 64'd0);

    // reset pulse at RUN cnt=20, then a clean 7*(-6)
    rsp_ready = 1'b0;
    issue(32'd3, 32'd5);
    repeat (21) @(posedge clk);
    #1;
    check("abort_in_run", 64'(dbg_state), 64'(RUN));
    rst = 1'b1;
    #1;
    check("abort_req_ready", 64'(req_ready), 64'd0);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_rsp_p", rsp_p, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen = 1;
    end
    check("abort_no_rsp", 64'(seen), 64'd0);
    check("abort_idle_ready", 64'(req_ready), 64'd1);
    mul_directed("post_abort", 32'd7, 32'hFFFFFFFA, 64'hFFFFFFFFFFFFFFD6);

    // random operands with random response stalls, checked through the expected queue
    rsp_ready = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      rx = $urandom;
      ry = $urandom;
      if (k == 0) rx = 32'h80000000;
      if (k == 1) ry = 32'h80000000;
      exp_q.push_back(model(rx, ry));
      issue(rx, ry);
      wait_rsp(lat);
      stall = $urandom_range(0, 3);
      repeat (stall) begin
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      check("rand_p", rsp_p, exp_q.pop_front());
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
